// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports,
// scoreboard set port and the init status flag.
interface reg_file_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic                 init_busy;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_pend;
    logic                 wr0_en;
    logic [AW-1:0]        wr0_addr;
    logic [XLEN-1:0]      wr0_data;
    logic                 wr1_en;
    logic [AW-1:0]        wr1_addr;
    logic [XLEN-1:0]      wr1_data;
    logic                 sb_set_en;
    logic [AW-1:0]        sb_set_addr;

    modport master (
        input  init_busy, rd_data, rd_pend,
        output rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr
    );

    modport slave (
        output init_busy, rd_data, rd_pend,
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two prioritised write ports with read bypass,
// optional hardwired x0, post-reset init sequencer and pending-write scoreboard.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_R0  = 1,
    parameter int INIT_IDX = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  rf
);
    localparam int NREG = 2**AW;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic [AW:0]       cnt, cnt_nxt;
    logic [XLEN-1:0]   regs [NREG];
    logic [NREG-1:0]   pend, pend_nxt;
    logic              run;
    logic              wr0_ok, wr1_ok, sb_ok;
    logic [XLEN-1:0]   init_val;
    logic [AW-1:0]     ra;

    assign run          = (state == ST_RUN);
    assign rf.init_busy = (state == ST_INIT);
    assign init_val     = (INIT_IDX != 0) ? XLEN'(cnt) : '0;

    // Writes that actually land: x0 filtering and wr0-over-wr1 priority on address clash
    assign wr0_ok = run && rf.wr0_en && !((ZERO_R0 != 0) && (rf.wr0_addr == '0));
    assign wr1_ok = run && rf.wr1_en && !((ZERO_R0 != 0) && (rf.wr1_addr == '0))
                    && !(rf.wr0_en && (rf.wr0_addr == rf.wr1_addr));
    assign sb_ok  = run && rf.sb_set_en && !((ZERO_R0 != 0) && (rf.sb_set_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == ST_INIT) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == (AW+1)'(NREG-1))
                state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                regs[cnt[AW-1:0]] <= init_val;
            end else begin
                if (wr1_ok) regs[rf.wr1_addr] <= rf.wr1_data;
                if (wr0_ok) regs[rf.wr0_addr] <= rf.wr0_data;
            end
        end
    end

    // Set is applied after clear so a freshly issued producer keeps the bit
    always_comb begin
        pend_nxt = pend;
        if (wr0_ok) pend_nxt[rf.wr0_addr] = 1'b0;
        if (wr1_ok) pend_nxt[rf.wr1_addr] = 1'b0;
        if (sb_ok)  pend_nxt[rf.sb_set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    always_comb begin
        rf.rd_data = '0;
        rf.rd_pend = '0;
        ra         = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rf.rd_addr[k*AW +: AW];
            if (run && !((ZERO_R0 != 0) && (ra == '0))) begin
                if (rf.wr0_en && (rf.wr0_addr == ra))
                    rf.rd_data[k*XLEN +: XLEN] = rf.wr0_data;
                else if (rf.wr1_en && (rf.wr1_addr == ra))
                    rf.rd_data[k*XLEN +: XLEN] = rf.wr1_data;
                else
                    rf.rd_data[k*XLEN +: XLEN] = regs[ra];
                rf.rd_pend[k] = pend[ra]
                                && !(wr0_ok && (rf.wr0_addr == ra))
                                && !(wr1_ok && (rf.wr1_addr == ra));
            end
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (x0 hardwired + index init, and plain x0 + zero init)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_reg_file_mp;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus_a ();
    reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus_b ();

    assign bus_b.rd_addr     = bus_a.rd_addr;
    assign bus_b.wr0_en      = bus_a.wr0_en;
    assign bus_b.wr0_addr    = bus_a.wr0_addr;
    assign bus_b.wr0_data    = bus_a.wr0_data;
    assign bus_b.wr1_en      = bus_a.wr1_en;
    assign bus_b.wr1_addr    = bus_a.wr1_addr;
    assign bus_b.wr1_data    = bus_a.wr1_data;
    assign bus_b.sb_set_en   = bus_a.sb_set_en;
    assign bus_b.sb_set_addr = bus_a.sb_set_addr;

    reg_file_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_R0(1), .INIT_IDX(1))
        dut_a (.clk(clk), .rst(rst), .rf(bus_a));
    reg_file_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_R0(0), .INIT_IDX(0))
        dut_b (.clk(clk), .rst(rst), .rf(bus_b));

    int vectors = 0;
    int errors  = 0;

    // Model state; config 0 = dut_a, config 1 = dut_b
    logic [XLEN-1:0] m_reg  [2][NREG];
    bit              m_pend [2][NREG];
    bit              m_init = 1'b1;
    int              m_cnt  = 0;
    bit              check_en = 1'b0;

    task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_init = 1'b1;
            m_cnt  = 0;
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < NREG; i++) m_pend[c][i] = 1'b0;
        end else if (m_init) begin
            m_reg[0][m_cnt] = XLEN'(m_cnt);
            m_reg[1][m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NREG) m_init = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                // wr1 applied first so wr0 overwrites it on a clash
                if (bus_a.wr1_en) begin
                    m_reg[c][bus_a.wr1_addr]  = bus_a.wr1_data;
                    m_pend[c][bus_a.wr1_addr] = 1'b0;
                end
                if (bus_a.wr0_en) begin
                    m_reg[c][bus_a.wr0_addr]  = bus_a.wr0_data;
                    m_pend[c][bus_a.wr0_addr] = 1'b0;
                end
                if (bus_a.sb_set_en) m_pend[c][bus_a.sb_set_addr] = 1'b1;
                if (c == 0) begin
                    m_reg[0][0]  = '0;
                    m_pend[0][0] = 1'b0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        check_en = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            for (int c = 0; c < 2; c++) begin
                logic              busy;
                logic [NRD*XLEN-1:0] dat;
                logic [NRD-1:0]    pnd;
                busy = (c == 0) ? bus_a.init_busy : bus_b.init_busy;
                dat  = (c == 0) ? bus_a.rd_data   : bus_b.rd_data;
                pnd  = (c == 0) ? bus_a.rd_pend   : bus_b.rd_pend;
                cmp($sformatf("busy[%0d]", c), XLEN'(busy), XLEN'(m_init));
                for (int k = 0; k < NRD; k++) begin
                    logic [AW-1:0]   a;
                    logic [XLEN-1:0] ed;
                    logic            ep;
                    a  = bus_a.rd_addr[k*AW +: AW];
                    ed = '0;
                    ep = 1'b0;
                    if (!m_init) begin
                        if (bus_a.wr0_en && bus_a.wr0_addr == a)      ed = bus_a.wr0_data;
                        else if (bus_a.wr1_en && bus_a.wr1_addr == a) ed = bus_a.wr1_data;
                        else                                          ed = m_reg[c][a];
                        ep = m_pend[c][a] && !(bus_a.wr0_en && bus_a.wr0_addr == a)
                                          && !(bus_a.wr1_en && bus_a.wr1_addr == a);
                        if (c == 0 && a == '0) begin
                            ed = '0;
                            ep = 1'b0;
                        end
                    end
                    cmp($sformatf("data[%0d][%0d]", c, k), dat[k*XLEN +: XLEN], ed);
                    cmp($sformatf("pend[%0d][%0d]", c, k), XLEN'(pnd[k]), XLEN'(ep));
                end
            end
        end
    end

    task automatic idle();
        bus_a.wr0_en = 1'b0; bus_a.wr0_addr = '0; bus_a.wr0_data = '0;
        bus_a.wr1_en = 1'b0; bus_a.wr1_addr = '0; bus_a.wr1_data = '0;
        bus_a.sb_set_en = 1'b0; bus_a.sb_set_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus_a.rd_addr = {a1, a0};
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!bus_a.init_busy) break;
            n++;
        end
        cmp(name, XLEN'(n), 32'd32);
    endtask

    initial begin
        idle();
        set_rd(5'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_init("init_len");

        step(); set_rd(5'd5, 5'd31);
        @(negedge clk);
        cmp("a_x5", bus_a.rd_data[31:0], 32'd5);
        cmp("a_x31", bus_a.rd_data[63:32], 32'd31);
        cmp("a_pend_init", XLEN'(bus_a.rd_pend), 32'd0);
        cmp("b_x5", bus_b.rd_data[31:0], 32'd0);
        cmp("b_x31", bus_b.rd_data[63:32], 32'd0);

        step(); set_rd(5'd7, 5'd31);
        bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd7; bus_a.wr0_data = 32'hDEADBEEF;
        @(negedge clk);
        cmp("bypass_x7", bus_a.rd_data[31:0], 32'hDEADBEEF);
        step();
        @(negedge clk);
        cmp("stored_x7", bus_a.rd_data[31:0], 32'hDEADBEEF);

        step(); set_rd(5'd9, 5'd10);
        bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd9; bus_a.wr0_data = 32'h11;
        bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 5'd9; bus_a.wr1_data = 32'h22;
        @(negedge clk);
        cmp("prio_bypass_x9", bus_a.rd_data[31:0], 32'h11);
        step();
        bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 5'd10; bus_a.wr1_data = 32'h33;
        @(negedge clk);
        cmp("prio_stored_x9", bus_a.rd_data[31:0], 32'h11);
        cmp("wr1_bypass_x10", bus_a.rd_data[63:32], 32'h33);
        step();
        @(negedge clk);
        cmp("wr1_stored_x10", bus_a.rd_data[63:32], 32'h33);

        step(); set_rd(5'd0, 5'd0);
        bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd0; bus_a.wr0_data = 32'h55;
        bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd0;
        @(negedge clk);
        cmp("a_x0_wr", bus_a.rd_data[31:0], 32'd0);
        cmp("b_x0_bypass", bus_b.rd_data[31:0], 32'h55);
        step();
        @(negedge clk);
        cmp("a_x0_after", bus_a.rd_data[31:0], 32'd0);
        cmp("a_x0_pend", XLEN'(bus_a.rd_pend), 32'd0);
        cmp("b_x0_after", bus_b.rd_data[31:0], 32'h55);
        cmp("b_x0_pend", XLEN'(bus_b.rd_pend), 32'd3);

        step(); set_rd(5'd12, 5'd12);
        bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd12;
        @(negedge clk);
        cmp("sb_same_cycle", XLEN'(bus_a.rd_pend), 32'd0);
        step();
        @(negedge clk);
        cmp("sb_next_cycle", XLEN'(bus_a.rd_pend), 32'd3);
        step();
        bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 5'd12; bus_a.wr1_data = 32'h77;
        @(negedge clk);
        cmp("sb_clr_pend", XLEN'(bus_a.rd_pend), 32'd0);
        cmp("sb_clr_data", bus_a.rd_data[31:0], 32'h77);
        step();
        @(negedge clk);
        cmp("sb_cleared", XLEN'(bus_a.rd_pend), 32'd0);
        step();
        bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd12;
        bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd12; bus_a.wr0_data = 32'h88;
        step();
        @(negedge clk);
        cmp("sb_set_wins", XLEN'(bus_a.rd_pend), 32'd3);
        cmp("sb_set_wins_data", bus_a.rd_data[31:0], 32'h88);

        step(); set_rd(5'd3, 5'd4);
        bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd3; bus_a.wr0_data = 32'hAA;
        step();
        @(negedge clk);
        cmp("x3_written", bus_a.rd_data[31:0], 32'hAA);
        step();
        rst = 1'b1;
        bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd4;
        bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd4; bus_a.wr0_data = 32'h99;
        step();
        rst = 1'b0;
        wait_init("reinit_len");
        step();
        @(negedge clk);
        cmp("reinit_x3", bus_a.rd_data[31:0], 32'd3);
        cmp("reinit_x4", bus_a.rd_data[63:32], 32'd4);
        cmp("reinit_pend", XLEN'(bus_a.rd_pend), 32'd0);
        cmp("b_reinit_pend", XLEN'(bus_b.rd_pend), 32'd0);

        step();
        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
